win_avg_ctrl: RTL and testbench

Frame sequencer for the windowed averager in the DOA datapath. It sits between the multi-stream sample source and the averager. It gates sample beats into fixed-length averaging frames and holds the averager's window length stable for the whole frame. It then waits for the averager's result handshake and reports frame completion, counts and errors to the PS-side register map.

---
 rtl/win_avg_ctrl_pkg.sv | 22 ++
 rtl/win_avg_ctrl_if.sv | 39 +++
 rtl/win_avg_ctrl_sat_cnt.sv | 32 +++
 rtl/win_avg_ctrl.sv | 144 ++++++++++++++
 tb/tb_win_avg_ctrl.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/win_avg_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// win_avg_pkg
// Shared types and constants for the windowed-averager frame sequencer.
//   state_e : sequencer states (IDLE, ARM, FILL, WAIT)
//   LEN_W   : window-length width
//   DEF_LEN : window length after reset
//   CNT_W   : width of the PS-visible frame/drop counters
// ---------------------------------------------------------------------------
package win_avg_pkg;

    localparam int LEN_W   = 5;
    localparam int DEF_LEN = 8;
    localparam int CNT_W   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        FILL = 2'd2,
        WAIT = 2'd3
    } state_e;

endpackage

// File: rtl/win_avg_ctrl_if.sv
// ---------------------------------------------------------------------------
// win_avg_ctrl_if
// Datapath bundle between the sample source, the frame sequencer and the
// windowed averager.
//   s_di / s_vi / s_ri            : source stream (data, valid, ready)
//   avg_win_len                   : window length presented to the averager
//   avg_di / avg_vi / avg_ri      : averager input stream
//   avg_vo / avg_ro               : averager result handshake (monitored only)
// master : sequencer side, slave : source/averager environment side.
// ---------------------------------------------------------------------------
interface win_avg_ctrl_if
    import win_avg_pkg::*;
#(
    parameter int STREAMS = 16,
    parameter int BITS    = 32,
    parameter int LW      = win_avg_pkg::LEN_W
);

    logic [BITS*STREAMS-1:0] s_di;
    logic                    s_vi;
    logic                    s_ri;
    logic [LW-1:0]           avg_win_len;
    logic [BITS*STREAMS-1:0] avg_di;
    logic                    avg_vi;
    logic                    avg_ri;
    logic                    avg_vo;
    logic                    avg_ro;

    modport master (
        input  s_di, s_vi, avg_ri, avg_vo, avg_ro,
        output s_ri, avg_win_len, avg_di, avg_vi
    );

    modport slave (
        output s_di, s_vi, avg_ri, avg_vo, avg_ro,
        input  s_ri, avg_win_len, avg_di, avg_vi
    );

endinterface

// File: rtl/win_avg_ctrl_sat_cnt.sv
// ---------------------------------------------------------------------------
// sat_cnt
// Saturating up-counter: holds at all-ones instead of wrapping.
//   clk   : clock
//   srst  : synchronous active-high reset (to zero)
//   clr_i : synchronous clear (to zero)
//   inc_i : increment request
//   cnt_o : current count
// ---------------------------------------------------------------------------
module sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (srst || clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/win_avg_ctrl.sv
// ---------------------------------------------------------------------------
// win_avg_ctrl
// Frame sequencer in front of the windowed averager. Gates source beats into
// fixed-length frames, freezes the averager window length for a whole frame,
// waits for the averager result handshake and reports status.
//   aclk, rst          : clock, synchronous active-high reset
//   cfg_win_len/cfg_we : window-length shadow register write
//   start / run        : single-frame pulse / continuous-mode level
//   bus (master)       : source stream, averager stream and result monitor
//   busy               : sequencer not IDLE
//   frame_done         : one-cycle pulse per completed frame
//   frame_cnt/drop_cnt : saturating completed-frame / discarded-beat counters
//   cfg_err / tmo_err  : sticky zero-length-write / result-timeout flags
// ---------------------------------------------------------------------------
module win_avg_ctrl
    import win_avg_pkg::*;
#(
    parameter int STREAMS = 16,
    parameter int BITS    = 32,
    parameter int LEN_W   = win_avg_pkg::LEN_W,
    parameter int DEF_LEN = win_avg_pkg::DEF_LEN,
    parameter int TMO     = 1024
) (
    input  logic              aclk,
    input  logic              rst,
    input  logic [LEN_W-1:0]  cfg_win_len,
    input  logic              cfg_we,
    input  logic              start,
    input  logic              run,
    win_avg_ctrl_if.master    bus,
    output logic              busy,
    output logic              frame_done,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic              cfg_err,
    output logic              tmo_err
);

    localparam int TMO_W = (TMO > 1) ? $clog2(TMO) : 1;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   shadow_q;
    logic [LEN_W-1:0]   win_len_q;
    logic [LEN_W-1:0]   beat_cnt_q;
    logic [TMO_W-1:0]   wait_cnt_q;
    logic               frame_done_q;
    logic               cfg_err_q;
    logic               tmo_err_q;

    logic               accept;
    logic               last_beat;
    logic               result_hs;
    logic               timeout;

    assign accept    = (state_q == FILL) && bus.s_vi && bus.avg_ri;
    assign last_beat = accept && (beat_cnt_q == win_len_q - 1'b1);
    assign result_hs = (state_q == WAIT) && bus.avg_vo && bus.avg_ro;
    // A result arriving in the very last wait cycle still wins over the timeout.
    assign timeout   = (state_q == WAIT) && !result_hs &&
                       (wait_cnt_q == TMO_W'(TMO - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start || run) state_d = ARM;
            ARM:     state_d = FILL;
            FILL:    if (last_beat) state_d = WAIT;
            WAIT: begin
                if (result_hs)    state_d = run ? ARM : IDLE;
                else if (timeout) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            state_q      <= IDLE;
            shadow_q     <= LEN_W'(DEF_LEN);
            win_len_q    <= LEN_W'(DEF_LEN);
            beat_cnt_q   <= '0;
            wait_cnt_q   <= '0;
            frame_done_q <= 1'b0;
            cfg_err_q    <= 1'b0;
            tmo_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_done_q <= result_hs;

            if (cfg_we) begin
                if (cfg_win_len != '0) shadow_q  <= cfg_win_len;
                else                   cfg_err_q <= 1'b1;
            end

            // Load the window length on entry to ARM so it is already stable
            // during the ARM cycle; a write landing in ARM only updates the
            // shadow and therefore applies to the following frame.
            if (state_d == ARM) win_len_q <= shadow_q;

            if (state_q == ARM)  beat_cnt_q <= '0;
            else if (accept)     beat_cnt_q <= beat_cnt_q + 1'b1;

            if (last_beat)              wait_cnt_q <= '0;
            else if (state_q == WAIT)   wait_cnt_q <= wait_cnt_q + 1'b1;

            if (timeout) tmo_err_q <= 1'b1;
        end
    end

    // Zero-latency pass-through of each stream lane.
    for (genvar gi = 0; gi < STREAMS; gi++) begin : g_lane
        assign bus.avg_di[gi*BITS +: BITS] = bus.s_di[gi*BITS +: BITS];
    end

    assign bus.avg_win_len = win_len_q;
    assign bus.avg_vi      = (state_q == FILL) && bus.s_vi;
    // IDLE keeps the source drained (beats are dropped); FILL follows the averager.
    assign bus.s_ri        = (state_q == IDLE) || ((state_q == FILL) && bus.avg_ri);

    // Counter 0: completed frames, counter 1: beats discarded in IDLE.
    logic [1:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_val [2];

    assign cnt_inc[0] = result_hs;
    assign cnt_inc[1] = (state_q == IDLE) && bus.s_vi;

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        sat_cnt #(.W(CNT_W)) u_cnt (
            .clk   (aclk),
            .srst  (rst),
            .clr_i (1'b0),
            .inc_i (cnt_inc[gi]),
            .cnt_o (cnt_val[gi])
        );
    end

    assign frame_cnt  = cnt_val[0];
    assign drop_cnt   = cnt_val[1];
    assign busy       = (state_q != IDLE);
    assign frame_done = frame_done_q;
    assign cfg_err    = cfg_err_q;
    assign tmo_err    = tmo_err_q;

endmodule

// File: tb/tb_win_avg_ctrl.sv
module tb_win_avg_ctrl;
    import win_avg_pkg::*;

    localparam int STREAMS = 16;
    localparam int BITS    = 32;
    localparam int TMO     = 1024;

    logic             aclk = 1'b0;
    logic             rst;
    logic [LEN_W-1:0] cfg_win_len;
    logic             cfg_we;
    logic             start;
    logic             run;
    logic             busy;
    logic             frame_done;
    logic [15:0]      frame_cnt;
    logic [15:0]      drop_cnt;
    logic             cfg_err;
    logic             tmo_err;

    int ncmp = 0;
    int nfail = 0;

    win_avg_ctrl_if #(.STREAMS(STREAMS), .BITS(BITS), .LW(LEN_W)) bus ();

    win_avg_ctrl #(
        .STREAMS(STREAMS), .BITS(BITS), .LEN_W(LEN_W), .DEF_LEN(DEF_LEN), .TMO(TMO)
    ) dut (
        .aclk        (aclk),
        .rst         (rst),
        .cfg_win_len (cfg_win_len),
        .cfg_we      (cfg_we),
        .start       (start),
        .run         (run),
        .bus         (bus),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_cnt   (frame_cnt),
        .drop_cnt    (drop_cnt),
        .cfg_err     (cfg_err),
        .tmo_err     (tmo_err)
    );

    always #5 aclk = ~aclk;

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; cfg_we = 1'b0; cfg_win_len = '0; start = 1'b0; run = 1'b0;
        bus.s_di = '0; bus.s_vi = 1'b0; bus.avg_ri = 1'b0; bus.avg_vo = 1'b0; bus.avg_ro = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; cfg_we = 1'b0; cfg_win_len = '0; start = 1'b0; run = 1'b0;
        bus.s_di = '0; bus.s_vi = 1'b0; bus.avg_ri = 1'b0; bus.avg_vo = 1'b0; bus.avg_ro = 1'b0;
        step();
        step();
        ncmp++; if (busy !== 1'b0) begin nfail++; $display("FAIL reset_busy: got %0b want 0", busy); end
        ncmp++; if (bus.avg_win_len !== 5'd8) begin nfail++; $display("FAIL reset_win_len: got %0d want 8", bus.avg_win_len); end
        ncmp++; if (bus.avg_vi !== 1'b0) begin nfail++; $display("FAIL reset_avg_vi: got %0b want 0", bus.avg_vi); end
        ncmp++; if (frame_done !== 1'b0) begin nfail++; $display("FAIL reset_frame_done: got %0b want 0", frame_done); end
        ncmp++; if (frame_cnt !== 16'd0 || drop_cnt !== 16'd0) begin nfail++; $display("FAIL reset_counters: got %0d/%0d want 0/0", frame_cnt, drop_cnt); end
        ncmp++; if (cfg_err !== 1'b0 || tmo_err !== 1'b0) begin nfail++; $display("FAIL reset_errors: got %0b/%0b want 0/0", cfg_err, tmo_err); end
        rst = 1'b0;
        step();
        ncmp++; if (bus.s_ri !== 1'b1) begin nfail++; $display("FAIL reset_s_ri: got %0b want 1", bus.s_ri); end
        $display("test_reset done");
    endtask

    task automatic test_single_frame();
        int fwd;
        int data_bad;
        logic [BITS*STREAMS-1:0] pat;
        do_reset();
        cfg_win_len = 5'd4; cfg_we = 1'b1;
        step();
        cfg_we = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        ncmp++; if (busy !== 1'b1) begin nfail++; $display("FAIL single_arm_busy: got %0b want 1", busy); end
        ncmp++; if (bus.avg_win_len !== 5'd4) begin nfail++; $display("FAIL single_arm_win_len: got %0d want 4", bus.avg_win_len); end
        bus.s_vi = 1'b1; bus.avg_ri = 1'b1;
        ncmp++; if (bus.s_ri !== 1'b0 || bus.avg_vi !== 1'b0) begin nfail++; $display("FAIL single_arm_no_beat: got s_ri=%0b avg_vi=%0b want 0/0", bus.s_ri, bus.avg_vi); end
        step();
        fwd = 0; data_bad = 0;
        for (int k = 0; k < 6; k++) begin
            pat = {STREAMS{32'hA500_0000 + 32'(k)}};
            bus.s_di = pat;
            if (bus.avg_vi && bus.avg_ri) begin
                fwd++;
                if (bus.avg_di !== pat) data_bad++;
            end
            step();
        end
        ncmp++; if (fwd !== 4) begin nfail++; $display("FAIL single_beats: got %0d want 4", fwd); end
        ncmp++; if (data_bad !== 0) begin nfail++; $display("FAIL single_data: got %0d bad beats want 0", data_bad); end
        ncmp++; if (bus.s_ri !== 1'b0 || bus.avg_vi !== 1'b0) begin nfail++; $display("FAIL single_wait_gate: got s_ri=%0b avg_vi=%0b want 0/0", bus.s_ri, bus.avg_vi); end
        ncmp++; if (bus.avg_win_len !== 5'd4 || frame_done !== 1'b0) begin nfail++; $display("FAIL single_wait_state: got len=%0d done=%0b want 4/0", bus.avg_win_len, frame_done); end
        bus.s_vi = 1'b0; bus.avg_vo = 1'b1; bus.avg_ro = 1'b1;
        step();
        bus.avg_vo = 1'b0; bus.avg_ro = 1'b0;
        ncmp++; if (frame_done !== 1'b1 || frame_cnt !== 16'd1) begin nfail++; $display("FAIL single_done: got done=%0b cnt=%0d want 1/1", frame_done, frame_cnt); end
        ncmp++; if (busy !== 1'b0) begin nfail++; $display("FAIL single_idle: got busy=%0b want 0", busy); end
        step();
        ncmp++; if (frame_done !== 1'b0 || frame_cnt !== 16'd1) begin nfail++; $display("FAIL single_pulse: got done=%0b cnt=%0d want 0/1", frame_done, frame_cnt); end
        $display("test_single_frame: %0d beats forwarded", fwd);
    endtask

    task automatic test_run_stalls();
        int beats, fb, hs, fd, gap_bad, last;
        bit pend, done;
        do_reset();
        beats = 0; fb = 0; hs = 0; fd = 0; gap_bad = 0; last = -100; pend = 0; done = 0;
        run = 1'b1; bus.s_vi = 1'b1;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            bus.avg_vo = pend; bus.avg_ro = pend;
            if (pend) begin
                pend = 0; hs++;
                if (hs == 3) run = 1'b0;
            end
            bus.avg_ri = 1'($urandom_range(0, 1));
            if (bus.avg_vi && bus.avg_ri) begin
                if (fb == 0 && beats != 0 && (cyc - last - 1) < 2) gap_bad++;
                beats++; fb++; last = cyc;
                if (fb == 8) begin fb = 0; pend = 1; end
            end
            step();
            if (frame_done) fd++;
            if (hs == 3 && !busy) done = 1;
        end
        bus.s_vi = 1'b0; bus.avg_vo = 1'b0; bus.avg_ro = 1'b0;
        ncmp++; if (done !== 1'b1) begin nfail++; $display("FAIL run_timeout: got done=%0b want 1 within 400 cycles", done); end
        ncmp++; if (beats !== 24) begin nfail++; $display("FAIL run_beats: got %0d want 24", beats); end
        ncmp++; if (frame_cnt !== 16'd3 || fd !== 3) begin nfail++; $display("FAIL run_frames: got cnt=%0d pulses=%0d want 3/3", frame_cnt, fd); end
        ncmp++; if (gap_bad !== 0) begin nfail++; $display("FAIL run_gap: got %0d short gaps want 0", gap_bad); end
        $display("test_run_stalls: %0d beats, %0d frames", beats, fd);
    endtask

    task automatic test_cfg_midframe();
        int fwd;
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0; bus.s_vi = 1'b1; bus.avg_ri = 1'b1;
        step();
        fwd = 0;
        for (int k = 0; k < 12; k++) begin
            cfg_we = (k == 3); cfg_win_len = 5'd2;
            if (bus.avg_vi && bus.avg_ri) fwd++;
            step();
        end
        cfg_we = 1'b0; bus.s_vi = 1'b0;
        ncmp++; if (fwd !== 8) begin nfail++; $display("FAIL cfg_cur_beats: got %0d want 8", fwd); end
        ncmp++; if (bus.avg_win_len !== 5'd8) begin nfail++; $display("FAIL cfg_cur_len: got %0d want 8", bus.avg_win_len); end
        bus.avg_vo = 1'b1; bus.avg_ro = 1'b1;
        step();
        bus.avg_vo = 1'b0; bus.avg_ro = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        ncmp++; if (bus.avg_win_len !== 5'd2) begin nfail++; $display("FAIL cfg_next_len: got %0d want 2", bus.avg_win_len); end
        bus.s_vi = 1'b1;
        step();
        fwd = 0;
        for (int k = 0; k < 6; k++) begin
            if (bus.avg_vi && bus.avg_ri) fwd++;
            step();
        end
        ncmp++; if (fwd !== 2) begin nfail++; $display("FAIL cfg_next_beats: got %0d want 2", fwd); end
        bus.s_vi = 1'b0; bus.avg_vo = 1'b1; bus.avg_ro = 1'b1;
        step();
        bus.avg_vo = 1'b0; bus.avg_ro = 1'b0;
        cfg_win_len = 5'd0; cfg_we = 1'b1;
        step();
        cfg_we = 1'b0;
        ncmp++; if (cfg_err !== 1'b1) begin nfail++; $display("FAIL cfg_zero_err: got %0b want 1", cfg_err); end
        start = 1'b1;
        step();
        start = 1'b0;
        ncmp++; if (bus.avg_win_len !== 5'd2) begin nfail++; $display("FAIL cfg_zero_keep: got %0d want 2", bus.avg_win_len); end
        cfg_win_len = 5'd5; cfg_we = 1'b1;
        step();
        cfg_we = 1'b0;
        ncmp++; if (bus.avg_win_len !== 5'd2) begin nfail++; $display("FAIL cfg_arm_write: got %0d want 2", bus.avg_win_len); end
        $display("test_cfg_midframe done");
    endtask

    task automatic test_drop();
        int vi_bad;
        do_reset();
        vi_bad = 0;
        bus.s_vi = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (bus.avg_vi !== 1'b0 || bus.s_ri !== 1'b1) vi_bad++;
            step();
        end
        bus.s_vi = 1'b0;
        ncmp++; if (vi_bad !== 0) begin nfail++; $display("FAIL drop_avg_vi: got %0d bad cycles want 0", vi_bad); end
        ncmp++; if (drop_cnt !== 16'd5) begin nfail++; $display("FAIL drop_cnt: got %0d want 5", drop_cnt); end
        ncmp++; if (busy !== 1'b0) begin nfail++; $display("FAIL drop_busy: got %0b want 0", busy); end
        $display("test_drop: drop_cnt=%0d", drop_cnt);
    endtask

    task automatic test_timeout();
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0; bus.s_vi = 1'b1; bus.avg_ri = 1'b1;
        step();
        for (int k = 0; k < 8; k++) step();
        bus.s_vi = 1'b0;
        for (int k = 0; k < TMO - 1; k++) step();
        ncmp++; if (busy !== 1'b1 || tmo_err !== 1'b0) begin nfail++; $display("FAIL tmo_early: got busy=%0b tmo=%0b want 1/0", busy, tmo_err); end
        step();
        ncmp++; if (busy !== 1'b0 || tmo_err !== 1'b1) begin nfail++; $display("FAIL tmo_fire: got busy=%0b tmo=%0b want 0/1", busy, tmo_err); end
        ncmp++; if (frame_cnt !== 16'd0 || frame_done !== 1'b0) begin nfail++; $display("FAIL tmo_no_frame: got cnt=%0d done=%0b want 0/0", frame_cnt, frame_done); end
        step();
        ncmp++; if (tmo_err !== 1'b1) begin nfail++; $display("FAIL tmo_sticky: got %0b want 1", tmo_err); end
        $display("test_timeout done");
    endtask

    task automatic test_rst_midframe();
        do_reset();
        cfg_win_len = 5'd6; cfg_we = 1'b1;
        step();
        cfg_we = 1'b0; start = 1'b1;
        step();
        start = 1'b0; bus.s_vi = 1'b1; bus.avg_ri = 1'b1;
        step();
        step();
        step();
        step();
        rst = 1'b1;
        step();
        ncmp++; if (busy !== 1'b0 || bus.avg_win_len !== 5'd8) begin nfail++; $display("FAIL rst_mid_state: got busy=%0b len=%0d want 0/8", busy, bus.avg_win_len); end
        ncmp++; if (frame_cnt !== 16'd0 || frame_done !== 1'b0) begin nfail++; $display("FAIL rst_mid_frame: got cnt=%0d done=%0b want 0/0", frame_cnt, frame_done); end
        ncmp++; if (bus.avg_vi !== 1'b0 || bus.s_ri !== 1'b1) begin nfail++; $display("FAIL rst_mid_stream: got avg_vi=%0b s_ri=%0b want 0/1", bus.avg_vi, bus.s_ri); end
        rst = 1'b0; bus.s_vi = 1'b0;
        step();
        $display("test_rst_midframe done");
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_run_stalls();
        test_cfg_midframe();
        test_drop();
        test_timeout();
        test_rst_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
